// File: rtl/sdrc_wb_arbiter.sv
// ---------------------------------------------------------------------------
// sdrc_wb_arbiter
//
// Purpose: shares the single Wishbone slave port of the SDRAM controller
// between NUM_MASTERS Wishbone requesters. A two-state FSM (IDLE/OWNED)
// hands out a registered one-hot grant using round-robin selection that
// starts one position after the previous owner. The grant is held for the
// owner's whole cycle (bursts are never split). Dropping the owner's cyc
// returns to IDLE, which leaves one dead cycle before the next grant.
//
// Optional feature: define SDRC_WB_ARB_TIMEOUT_EN to add a stall watchdog.
// When the owner's strobe goes unacknowledged for TIMEOUT cycles, the owner
// gets a one-cycle m_err_o pulse, the cycle is aborted, and that master is
// locked out until it drops its m_cyc_i. Without the macro there is no
// counter, m_err_o is tied low and an owner may stall indefinitely.
//
// Ports:
//   wb_clk_i, wb_rst_i   clock, synchronous active-high reset
//   m_cyc_i/m_stb_i/m_we_i              per-master control (one bit each)
//   m_addr_i/m_dat_i/m_sel_i/m_cti_i    per-master buses, master i in slice i
//   m_ack_o/m_err_o      per-master responses; only the owner's bit moves
//   m_dat_o              shared read data (straight from s_dat_i)
//   s_cyc_o..s_cti_o     Wishbone master side towards the SDRAM controller
//   s_ack_i/s_dat_i      responses from the SDRAM controller
//   grant_o              one-hot current owner, all-zero when idle
// ---------------------------------------------------------------------------
module sdrc_wb_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int data_width  = 32,
  parameter int addr_width  = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic                                  wb_clk_i,
  input  logic                                  wb_rst_i,
  input  logic [NUM_MASTERS-1:0]                m_cyc_i,
  input  logic [NUM_MASTERS-1:0]                m_stb_i,
  input  logic [NUM_MASTERS-1:0]                m_we_i,
  input  logic [NUM_MASTERS*addr_width-1:0]     m_addr_i,
  input  logic [NUM_MASTERS*data_width-1:0]     m_dat_i,
  input  logic [NUM_MASTERS*(data_width/8)-1:0] m_sel_i,
  input  logic [NUM_MASTERS*3-1:0]              m_cti_i,
  output logic [NUM_MASTERS-1:0]                m_ack_o,
  output logic [NUM_MASTERS-1:0]                m_err_o,
  output logic [data_width-1:0]                 m_dat_o,
  output logic                                  s_cyc_o,
  output logic                                  s_stb_o,
  output logic                                  s_we_o,
  output logic [addr_width-1:0]                 s_addr_o,
  output logic [data_width-1:0]                 s_dat_o,
  output logic [(data_width/8)-1:0]             s_sel_o,
  output logic [2:0]                            s_cti_o,
  input  logic                                  s_ack_i,
  input  logic [data_width-1:0]                 s_dat_i,
  output logic [NUM_MASTERS-1:0]                grant_o
);

  localparam int OW = $clog2(NUM_MASTERS);
  localparam int SW = data_width / 8;

  // Parameter sanity: the watchdog counter is 8 bits wide, and the owner
  // index width assumes at least two masters.
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_badTimeout
    $error("sdrc_wb_arbiter: TIMEOUT must be in 1..255");
  end
  if (NUM_MASTERS < 2 || NUM_MASTERS > 8) begin : g_badMasters
    $error("sdrc_wb_arbiter: NUM_MASTERS must be in 2..8");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  state_t                 r_state;
  logic [OW-1:0]          r_owner;
  logic [OW-1:0]          r_last;
  logic [NUM_MASTERS-1:0] r_grant;

  logic [NUM_MASTERS-1:0] w_req;
  logic                   w_found;
  logic [OW-1:0]          w_winner;
  logic                   w_abort;

  // Round-robin search: walk from last_owner+1 upward with wrap-around and
  // take the first eligible requester. Ending the walk at last_owner itself
  // lets a lone requester win again after its own turn.
  always_comb begin
    logic [OW-1:0] cand;
    cand     = '0;
    w_found  = 1'b0;
    w_winner = r_last;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      cand = OW'((int'(r_last) + k) % NUM_MASTERS);
      if (!w_found && w_req[cand]) begin
        w_found  = 1'b1;
        w_winner = cand;
      end
    end
  end

`ifdef SDRC_WB_ARB_TIMEOUT_EN
  logic [7:0]             r_toCnt;
  logic [NUM_MASTERS-1:0] r_excl;
  logic                   w_stall;

  // A stalled cycle is one where the owner strobes and the slave does not
  // answer. The abort fires in the stalled cycle that would take the count
  // to TIMEOUT, so err is visible in that same cycle.
  assign w_stall = (r_state == OWNED) && m_stb_i[r_owner] && !s_ack_i;
  assign w_abort = w_stall && (r_toCnt == 8'(TIMEOUT - 1));
  assign m_err_o = w_abort ? r_grant : '0;

  // A timed-out master stays excluded until it drops its cyc; exclusion is
  // per master and evaporates as soon as cyc is seen low.
  assign w_req   = m_cyc_i & ~r_excl;

  // Watchdog counter and lock-out bookkeeping.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_toCnt <= '0;
      r_excl  <= '0;
    end else begin
      r_excl <= (r_excl | (w_abort ? r_grant : '0)) & m_cyc_i;
      if (r_state != OWNED || s_ack_i || w_abort || !m_cyc_i[r_owner]) begin
        r_toCnt <= '0;
      end else if (w_stall) begin
        r_toCnt <= r_toCnt + 8'd1;
      end
    end
  end
`else
  assign w_abort = 1'b0;
  assign w_req   = m_cyc_i;
  assign m_err_o = '0;
`endif

  // Arbitration FSM. The grant is registered so that a request seen in IDLE
  // shows up as grant/s_cyc_o exactly one cycle later. Leaving OWNED clears
  // the grant, which forces the dead IDLE cycle between owners.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_owner <= '0;
      r_last  <= OW'(NUM_MASTERS - 1);
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state <= OWNED;
            r_owner <= w_winner;
            r_last  <= w_winner;
            r_grant <= {{(NUM_MASTERS-1){1'b0}}, 1'b1} << w_winner;
          end
        end
        OWNED: begin
          if (!m_cyc_i[r_owner] || w_abort) begin
            r_state <= IDLE;
            r_grant <= '0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

  // Slave-side mux: while owned, the owner's request lines pass straight
  // through; in IDLE everything towards the slave is held at zero.
  always_comb begin
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_addr_o = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    s_cti_o  = '0;
    if (r_state == OWNED) begin
      s_stb_o  = m_stb_i[r_owner];
      s_we_o   = m_we_i[r_owner];
      s_addr_o = m_addr_i[int'(r_owner)*addr_width +: addr_width];
      s_dat_o  = m_dat_i[int'(r_owner)*data_width +: data_width];
      s_sel_o  = m_sel_i[int'(r_owner)*SW +: SW];
      s_cti_o  = m_cti_i[int'(r_owner)*3 +: 3];
    end
  end

  // The registered grant is all-zero outside OWNED, so it doubles as the
  // ack steering mask and the cycle indicator.
  assign s_cyc_o = (r_state == OWNED);
  assign grant_o = r_grant;
  assign m_ack_o = s_ack_i ? r_grant : '0;
  assign m_dat_o = s_dat_i;

endmodule

// File: tb/tb_sdrc_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sdrc_wb_arbiter
//
// Drives directed scenarios followed by a randomized phase into
// sdrc_wb_arbiter (4 masters, 32-bit buses, TIMEOUT=16). A behavioural
// model (owner index, last owner, stall count, lock-out mask) predicts every
// output each cycle. Define SDRC_WB_ARB_TIMEOUT_EN for both files to cover
// the watchdog build.
// ---------------------------------------------------------------------------
module tb_sdrc_wb_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 16;
`ifdef SDRC_WB_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  logic [N-1:0]  cyc, stb, we;
  logic [AW-1:0] addrA [N];
  logic [DW-1:0] datA  [N];
  logic [SW-1:0] selA  [N];
  logic [2:0]    ctiA  [N];
  logic          sAck;
  logic [DW-1:0] sDatIn;

  logic [N*AW-1:0] addrFlat;
  logic [N*DW-1:0] datFlat;
  logic [N*SW-1:0] selFlat;
  logic [N*3-1:0]  ctiFlat;

  logic [N-1:0]  mAck, mErr, grant;
  logic [DW-1:0] mDatOut;
  logic          sCyc, sStb, sWe;
  logic [AW-1:0] sAddr;
  logic [DW-1:0] sDat;
  logic [SW-1:0] sSel;
  logic [2:0]    sCti;

  int checks;
  int failures;

  // Behavioural model state: owner is -1 when nobody holds the bus.
  int           mOwner;
  int           mLast;
  int           mCnt;
  logic [N-1:0] mExcl;

  // Observed values from the most recent checked cycle.
  logic [N-1:0]  lastGrant, lastAck, lastErr;
  logic          lastSCyc;
  logic [AW-1:0] lastSAddr;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign addrFlat[g*AW +: AW] = addrA[g];
    assign datFlat[g*DW +: DW]  = datA[g];
    assign selFlat[g*SW +: SW]  = selA[g];
    assign ctiFlat[g*3 +: 3]    = ctiA[g];
  end

  sdrc_wb_arbiter #(
    .NUM_MASTERS(N),
    .data_width (DW),
    .addr_width (AW),
    .TIMEOUT    (TO)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .m_cyc_i (cyc),
    .m_stb_i (stb),
    .m_we_i  (we),
    .m_addr_i(addrFlat),
    .m_dat_i (datFlat),
    .m_sel_i (selFlat),
    .m_cti_i (ctiFlat),
    .m_ack_o (mAck),
    .m_err_o (mErr),
    .m_dat_o (mDatOut),
    .s_cyc_o (sCyc),
    .s_stb_o (sStb),
    .s_we_o  (sWe),
    .s_addr_o(sAddr),
    .s_dat_o (sDat),
    .s_sel_o (sSel),
    .s_cti_o (sCti),
    .s_ack_i (sAck),
    .s_dat_i (sDatIn),
    .grant_o (grant)
  );

  // One comparison: counts it, and on mismatch counts a failure and reports.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advances the model by one clock edge using the inputs the DUT sampled.
  task automatic modelUpdate();
    logic         abort;
    logic         found;
    logic [N-1:0] newExcl;
    int           c;
    if (rst) begin
      mOwner = -1;
      mLast  = N - 1;
      mCnt   = 0;
      mExcl  = '0;
    end else begin
      abort = TO_EN && (mOwner >= 0) && stb[mOwner] && !sAck && (mCnt == TO - 1);
      newExcl = mExcl;
      if (abort) newExcl[mOwner] = 1'b1;
      newExcl = newExcl & cyc;
      if (mOwner < 0) begin
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
          c = (mLast + k) % N;
          if (!found && cyc[c] && !mExcl[c]) begin
            found  = 1'b1;
            mOwner = c;
            mLast  = c;
          end
        end
        mCnt = 0;
      end else if (abort || !cyc[mOwner]) begin
        mOwner = -1;
        mCnt   = 0;
      end else if (sAck) begin
        mCnt = 0;
      end else if (stb[mOwner]) begin
        mCnt = mCnt + 1;
      end
      mExcl = newExcl;
    end
  endtask

  // One clock cycle: check all outputs mid-cycle against the model, then
  // step the model at the edge. Inputs are changed 1ns after the edge.
  task automatic applyStimulus();
    logic [N-1:0]  eGrant, eAck, eErr;
    logic          eCyc, eStb, eWe;
    logic [AW-1:0] eAddr;
    logic [DW-1:0] eDat;
    logic [SW-1:0] eSel;
    logic [2:0]    eCti;
    @(negedge clk);
    eGrant = '0; eAck = '0; eErr = '0;
    eCyc = 1'b0; eStb = 1'b0; eWe = 1'b0;
    eAddr = '0; eDat = '0; eSel = '0; eCti = '0;
    if (mOwner >= 0) begin
      eGrant[mOwner] = 1'b1;
      eCyc  = 1'b1;
      eStb  = stb[mOwner];
      eWe   = we[mOwner];
      eAddr = addrA[mOwner];
      eDat  = datA[mOwner];
      eSel  = selA[mOwner];
      eCti  = ctiA[mOwner];
      if (sAck) eAck[mOwner] = 1'b1;
      if (TO_EN && stb[mOwner] && !sAck && mCnt == TO - 1) eErr[mOwner] = 1'b1;
    end
    checkOutput("grant_o",  64'(grant),   64'(eGrant));
    checkOutput("s_cyc_o",  64'(sCyc),    64'(eCyc));
    checkOutput("s_stb_o",  64'(sStb),    64'(eStb));
    checkOutput("s_we_o",   64'(sWe),     64'(eWe));
    checkOutput("s_addr_o", 64'(sAddr),   64'(eAddr));
    checkOutput("s_dat_o",  64'(sDat),    64'(eDat));
    checkOutput("s_sel_o",  64'(sSel),    64'(eSel));
    checkOutput("s_cti_o",  64'(sCti),    64'(eCti));
    checkOutput("m_ack_o",  64'(mAck),    64'(eAck));
    checkOutput("m_err_o",  64'(mErr),    64'(eErr));
    checkOutput("m_dat_o",  64'(mDatOut), 64'(sDatIn));
    lastGrant = grant;
    lastAck   = mAck;
    lastErr   = mErr;
    lastSCyc  = sCyc;
    lastSAddr = sAddr;
    @(posedge clk);
    modelUpdate();
    #1;
  endtask

  task automatic clearAll();
    cyc = '0; stb = '0; we = '0;
    for (int i = 0; i < N; i++) begin
      addrA[i] = '0; datA[i] = '0; selA[i] = '0; ctiA[i] = '0;
    end
    sAck = 1'b0; sDatIn = '0; rst = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
  endtask

  initial begin
    int           order [$];
    logic [N-1:0] prevGrant, ackedNow;
    logic [N-1:0] expOrder [4];
    int           ackCount;

    checks = 0; failures = 0;
    mOwner = -1; mLast = N - 1; mCnt = 0; mExcl = '0;
    clearAll();

    // Reset state
    doReset();
    applyStimulus();
    checkOutput("reset_grant", 64'(lastGrant), 64'h0);
    checkOutput("reset_scyc",  64'(lastSCyc),  64'h0);

    // Master 2 write to 0x100, granted one cycle later, ack routed to it only
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1;
    addrA[2] = 32'h100; datA[2] = $urandom; selA[2] = 4'hF;
    applyStimulus();
    checkOutput("m2_idle_grant", 64'(lastGrant), 64'h0);
    sAck = 1'b1; sDatIn = $urandom;
    applyStimulus();
    checkOutput("m2_grant", 64'(lastGrant), 64'b0100);
    checkOutput("m2_addr",  64'(lastSAddr), 64'h100);
    checkOutput("m2_ack",   64'(lastAck),   64'b0100);
    clearAll();
    applyStimulus();
    applyStimulus();
    checkOutput("m2_release_scyc", 64'(lastSCyc), 64'h0);

    // Masters 0,1,3 contend; each drops cyc for one cycle after its ack
    doReset();
    cyc = 4'b1011; stb = 4'b1011;
    prevGrant = '0;
    for (int c = 0; c < 40 && order.size() < 4; c++) begin
      sAck = (mOwner >= 0) && cyc[mOwner] && stb[mOwner];
      ackedNow = '0;
      if (sAck) ackedNow[mOwner] = 1'b1;
      applyStimulus();
      if (lastGrant != '0 && lastGrant != prevGrant) order.push_back(int'(lastGrant));
      prevGrant = lastGrant;
      for (int m = 0; m < N; m++) begin
        if (m != 2) begin
          cyc[m] = !ackedNow[m];
          stb[m] = !ackedNow[m];
        end
      end
    end
    expOrder[0] = 4'b0001; expOrder[1] = 4'b0010;
    expOrder[2] = 4'b1000; expOrder[3] = 4'b0001;
    checkOutput("rr_count", 64'(order.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("rr_order%0d", i),
                  64'((i < order.size()) ? order[i] : 0), 64'(expOrder[i]));
    end
    clearAll();
    applyStimulus();
    applyStimulus();

    // 8-beat burst from master 1 while master 0 waits
    doReset();
    cyc[1] = 1'b1; stb[1] = 1'b1; selA[1] = 4'hF;
    ctiA[1] = 3'b010; addrA[1] = 32'h2000;
    applyStimulus();
    cyc[0] = 1'b1; stb[0] = 1'b1;
    ackCount = 0;
    for (int b = 0; b < 8; b++) begin
      addrA[1] = 32'h2000 + 32'(4 * b);
      ctiA[1]  = (b == 7) ? 3'b111 : 3'b010;
      datA[1]  = $urandom;
      sAck = 1'b1; sDatIn = $urandom;
      applyStimulus();
      if (lastAck[1]) ackCount++;
      checkOutput($sformatf("burst_grant_b%0d", b), 64'(lastGrant), 64'b0010);
    end
    cyc[1] = 1'b0; stb[1] = 1'b0; sAck = 1'b0;
    applyStimulus();
    checkOutput("burst_acks", 64'(ackCount), 64'd8);
    applyStimulus();
    checkOutput("burst_dead_grant", 64'(lastGrant), 64'h0);
    applyStimulus();
    checkOutput("burst_next_grant", 64'(lastGrant), 64'b0001);
    clearAll();
    applyStimulus();
    applyStimulus();

    // Reset pulse on the 4th beat of a burst
    doReset();
    cyc[1] = 1'b1; stb[1] = 1'b1; ctiA[1] = 3'b010;
    applyStimulus();
    for (int b = 0; b < 4; b++) begin
      addrA[1] = 32'h3000 + 32'(4 * b);
      sAck = 1'b1;
      if (b == 3) rst = 1'b1;
      applyStimulus();
    end
    clearAll();
    applyStimulus();
    checkOutput("rstburst_scyc",  64'(lastSCyc),  64'h0);
    checkOutput("rstburst_grant", 64'(lastGrant), 64'h0);
    checkOutput("rstburst_ack",   64'(lastAck),   64'h0);
    cyc[3] = 1'b1; stb[3] = 1'b1;
    applyStimulus();
    applyStimulus();
    checkOutput("rstburst_m3_grant", 64'(lastGrant), 64'b1000);
    clearAll();
    applyStimulus();
    applyStimulus();

    // Lone master 3 drops cyc together with its ack, then wins again
    doReset();
    cyc[3] = 1'b1; stb[3] = 1'b1;
    applyStimulus();
    cyc[3] = 1'b0; sAck = 1'b1;
    applyStimulus();
    checkOutput("lone_ack_on_drop", 64'(lastAck), 64'b1000);
    sAck = 1'b0; stb[3] = 1'b0;
    applyStimulus();
    checkOutput("lone_idle_grant", 64'(lastGrant), 64'h0);
    cyc[3] = 1'b1; stb[3] = 1'b1;
    applyStimulus();
    applyStimulus();
    checkOutput("lone_regrant", 64'(lastGrant), 64'b1000);
    clearAll();
    applyStimulus();
    applyStimulus();

    // Slave never acks master 0
    doReset();
    cyc[0] = 1'b1; stb[0] = 1'b1;
    applyStimulus();
    for (int s = 1; s <= TO; s++) begin
      applyStimulus();
      checkOutput($sformatf("stall_err_s%0d", s), 64'(lastErr),
                  64'((TO_EN && s == TO) ? 4'b0001 : 4'b0000));
    end
    applyStimulus();
    checkOutput("stall_after_scyc",  64'(lastSCyc),  64'(!TO_EN));
    checkOutput("stall_after_grant", 64'(lastGrant), 64'(TO_EN ? 4'b0000 : 4'b0001));
    applyStimulus();
    checkOutput("stall_locked_grant", 64'(lastGrant), 64'(TO_EN ? 4'b0000 : 4'b0001));
    cyc[0] = 1'b0; stb[0] = 1'b0;
    applyStimulus();
    cyc[0] = 1'b1; stb[0] = 1'b1; sAck = 1'b1;
    applyStimulus();
    applyStimulus();
    checkOutput("stall_regrant", 64'(lastGrant), 64'b0001);
    clearAll();
    applyStimulus();
    applyStimulus();

    // Randomized traffic against the model
    doReset();
    for (int c = 0; c < 400; c++) begin
      for (int m = 0; m < N; m++) begin
        if ($urandom_range(3) == 0) cyc[m] = ~cyc[m];
        stb[m]   = cyc[m] & 1'($urandom_range(1));
        we[m]    = 1'($urandom_range(1));
        addrA[m] = $urandom;
        datA[m]  = $urandom;
        selA[m]  = 4'($urandom);
        ctiA[m]  = 3'($urandom);
      end
      sAck   = ($urandom_range(3) != 0) ? 1'b0 : 1'b1;
      sDatIn = $urandom;
      rst    = ($urandom_range(63) == 0);
      applyStimulus();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdrc_wb_arbiter.md
SDRC_WB_ARBITER -- requirements
Module: sdrc_wb_arbiter

Interface
REQ-001 Parameter: NUM_MASTERS, default 4, number of Wishbone requesters sharing the SDRAM controller port (2..8).
REQ-002 Parameter: data_width, default 32, Wishbone data width.
REQ-003 Parameter: addr_width, default 32, Wishbone address width.
REQ-004 Parameter: TIMEOUT, default 255, stalled-strobe cycles before abort (used only with REQ-030).
REQ-005 Port: wb_clk_i  in  1  sole clock; all logic on its rising edge.
REQ-006 Port: wb_rst_i  in  1  reset, synchronous, active-high.
REQ-007 Ports: m_cyc_i, m_stb_i, m_we_i  in  NUM_MASTERS each  per-master cycle, strobe and write-enable.
REQ-008 Ports: m_addr_i  in  NUM_MASTERS*addr_width; m_dat_i  in  NUM_MASTERS*data_width; m_sel_i  in  NUM_MASTERS*data_width/8; m_cti_i  in  NUM_MASTERS*3; master i occupies slice i.
REQ-009 Ports: m_ack_o, m_err_o  out  NUM_MASTERS each; m_dat_o  out  data_width, shared read data.
REQ-010 Ports: s_cyc_o, s_stb_o, s_we_o  out  1; s_addr_o  out  addr_width; s_dat_o  out  data_width; s_sel_o  out  data_width/8; s_cti_o  out  3; drive the SDRAM controller Wishbone slave.
REQ-011 Ports: s_ack_i  in  1; s_dat_i  in  data_width; slave responses.
REQ-012 Port: grant_o  out  NUM_MASTERS  one-hot current owner; all-zero when idle.

Function
REQ-013 FSM states: IDLE and OWNED only.
REQ-014 IDLE: if any m_cyc_i bit is high, the arbiter shall register a one-hot grant and enter OWNED on the next edge; otherwise it stays in IDLE.
REQ-015 Selection: round-robin, searching from (last_owner+1) mod NUM_MASTERS upward with wrap-around; the winner becomes last_owner.
REQ-016 Latency: m_cyc_i asserted in IDLE at cycle n -> grant_o and s_cyc_o high at cycle n+1.
REQ-017 OWNED: s_cyc_o=1; s_stb_o, s_we_o, s_addr_o, s_dat_o, s_sel_o and s_cti_o combinationally mirror the owner's inputs.
REQ-018 m_ack_o[owner]=s_ack_i; every non-owner m_ack_o and m_err_o bit shall be 0; m_dat_o=s_dat_i.
REQ-019 Grant is held for the whole owner cycle (bursts with cti=010 never split), regardless of other requests.
REQ-020 OWNED->IDLE on the edge where m_cyc_i[owner] is sampled low; s_cyc_o and s_stb_o are 0 that cycle, giving one dead cycle before any regrant.
REQ-021 Owner deasserting cyc in the same cycle as s_ack_i: the ack is still forwarded, then the state returns to IDLE.
REQ-022 Requests appearing or disappearing from non-owners during OWNED shall have no effect on the slave outputs.
REQ-023 A master that drops m_cyc_i while not granted forfeits its turn, with no state retained.
REQ-024 In IDLE, every slave output and every grant, ack and err bit shall be 0.

Reset
REQ-025 wb_rst_i high at an edge: the state shall go to IDLE, grant_o=0, last_owner=NUM_MASTERS-1 (so master 0 wins first), and the timeout counter shall clear.
REQ-026 Reset mid-burst aborts immediately: s_cyc_o/s_stb_o=0 from the next cycle, with no ack or err forwarded.
REQ-027 After reset release, arbitration resumes at the first edge with wb_rst_i low.

Configuration
REQ-028 Macro SDRC_WB_ARB_TIMEOUT_EN selects the stall watchdog.
REQ-029 Without the macro: no counter is present, m_err_o is tied to 0, and an owner may stall indefinitely.
REQ-030 With the macro:
- An 8-bit counter increments each OWNED cycle with s_stb_o=1 and s_ack_i=0, and clears on any s_ack_i or on leaving OWNED.
- When the counter reaches TIMEOUT, m_err_o[owner] shall pulse for one cycle, and s_cyc_o/s_stb_o shall go 0 the following cycle.
- The state shall then return to IDLE; the owner is excluded until it drops m_cyc_i.

Verification
REQ-031 Reset, then master 2 asserts cyc/stb write addr 0x100 -> grant_o=4'b0100 one cycle later; s_addr_o=0x100; ack routed only to m_ack_o[2].
REQ-032 Masters 0,1,3 request together continuously, each dropping cyc after one ack -> grant order 0,1,3,0, with one idle cycle between grants.
REQ-033 Master 1 issues an 8-beat incrementing burst (cti 010..111) while master 0 requests -> 8 consecutive acks to master 1, then master 0 granted.
REQ-034 wb_rst_i pulsed for one cycle during the 4th beat of a burst -> s_cyc_o=0 the next cycle, grant_o=0, and a subsequent request from master 3 is granted normally.
REQ-035 Only master 3 requests, owner drops cyc with ack -> IDLE, then master 3 requests again and wins (wrap-around to 0 finds no other request).
REQ-036 With SDRC_WB_ARB_TIMEOUT_EN and TIMEOUT=16, the slave never acks master 0 -> m_err_o[0] pulses in the 16th stalled cycle and s_cyc_o is 0 the next cycle; without the macro, no err and the grant is held.
